// File: rtl/sram_arb_pkg.sv
// Shared types for the SRAM port arbiter: FSM state encoding and requester id type.
package sram_arb_pkg;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_ISSUE = 1'b1
    } arb_state_t;

    // Largest supported requester count; ids are sized for it so any NUM_REQ fits.
    localparam int MAX_REQ = 8;

    // Bits needed to encode values 0..value-1 (at least one bit).
    function automatic int clog2_fn(input int value);
        int w;
        w = 1;
        for (int i = 1; i < 31; i++) begin
            if (int'(32'd1 << i) < value) begin
                w = i + 1;
            end else begin
                w = w;
            end
        end
        return w;
    endfunction

    localparam int REQ_ID_W = clog2_fn(MAX_REQ);

    typedef logic [REQ_ID_W-1:0] req_id_t;

endpackage

// File: rtl/sram_arb_owner_fifo.sv
// Read-owner FIFO: remembers which requester issued each outstanding read, in issue order.
// Push and pop in the same cycle are accepted even when full.
module sram_arb_owner_fifo
    import sram_arb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic    clock,
    input  logic    reset,
    input  logic    push_i,
    input  req_id_t push_id_i,
    input  logic    pop_i,
    output logic    full_o,
    output logic    empty_o,
    output req_id_t head_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    req_id_t          mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push_s;
    logic             do_pop_s;

    // Status flags, qualified push/pop and the head entry.
    always_comb begin
        empty_o   = (count_q == '0);
        full_o    = (count_q == CNT_W'(DEPTH));
        do_pop_s  = pop_i & ~empty_o;
        do_push_s = push_i & (~full_o | do_pop_s);
        head_o    = mem_q[rd_ptr_q];
    end

    // Storage, pointers and occupancy count.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (do_push_s) begin
                mem_q[wr_ptr_q] <= push_id_i;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop_s) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/sram_port_arbiter.sv
// Round-robin arbiter sharing one Avalon-MM SRAM port between NUM_REQ masters, one
// transaction per grant, with read-return routing through an owner FIFO.
// Optional build macro SRAM_ARB_PRIO0_EN: requester 0 gets strict priority and the
// round-robin runs only among requesters 1..NUM_REQ-1.
module sram_port_arbiter
    import sram_arb_pkg::*;
#(
    parameter int NUM_REQ         = 3,
    parameter int MAX_OUTSTANDING = 4,
    parameter int ADDR_W          = 26
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_read,
    input  logic [NUM_REQ-1:0]        req_write,
    input  logic [NUM_REQ*ADDR_W-1:0] req_address,
    input  logic [NUM_REQ*32-1:0]     req_writedata,
    output logic [NUM_REQ-1:0]        req_waitrequest,
    output logic [31:0]               req_readdata,
    output logic [NUM_REQ-1:0]        req_readdatavalid,
    output logic                      m_read,
    output logic                      m_write,
    output logic [ADDR_W-1:0]         m_address,
    output logic [31:0]               m_writedata,
    input  logic                      m_waitrequest,
    input  logic [31:0]               m_readdata,
    input  logic                      m_readdatavalid,
    output logic                      err_orphan
);

    arb_state_t         state_q;
    req_id_t            grant_q;
    req_id_t            last_grant_q;
    logic               err_orphan_q;
    logic [NUM_REQ-1:0] eligible_s;
    logic [NUM_REQ-1:0] grant_oh_s;
    logic               pick_valid_s;
    req_id_t            pick_id_s;
    int                 idx_s;
    logic               accept_s;
    logic               push_s;
    logic               pop_s;
    logic               fifo_full_s;
    logic               fifo_empty_s;
    req_id_t            fifo_head_s;

    sram_arb_owner_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_owner_fifo (
        .clock     (clock),
        .reset     (reset),
        .push_i    (push_s),
        .push_id_i (grant_q),
        .pop_i     (pop_s),
        .full_o    (fifo_full_s),
        .empty_o   (fifo_empty_s),
        .head_o    (fifo_head_s)
    );

    // A read (which also wins over a simultaneous write) is eligible only with FIFO room.
    always_comb begin
        eligible_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_read[i]) begin
                eligible_s[i] = ~fifo_full_s;
            end else begin
                eligible_s[i] = req_write[i];
            end
        end
    end

    // Choose the first eligible requester after the last grant, wrapping.
    always_comb begin
        pick_valid_s = 1'b0;
        pick_id_s    = '0;
        idx_s        = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx_s = (int'(last_grant_q) + k) % NUM_REQ;
            for (int i = 0; i < NUM_REQ; i++) begin
`ifdef SRAM_ARB_PRIO0_EN
                if (!pick_valid_s && (i == idx_s) && (i != 0) && eligible_s[i]) begin
`else
                if (!pick_valid_s && (i == idx_s) && eligible_s[i]) begin
`endif
                    pick_valid_s = 1'b1;
                    pick_id_s    = REQ_ID_W'(i);
                end else begin
                    pick_valid_s = pick_valid_s;
                end
            end
        end
`ifdef SRAM_ARB_PRIO0_EN
        if (eligible_s[0]) begin
            pick_valid_s = 1'b1;
            pick_id_s    = '0;
        end else begin
            pick_valid_s = pick_valid_s;
        end
`endif
    end

    // Forward the granted requester to the master port while issuing; accept on no-wait.
    always_comb begin
        grant_oh_s  = '0;
        m_read      = 1'b0;
        m_write     = 1'b0;
        m_address   = '0;
        m_writedata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if ((state_q == ARB_ISSUE) && (grant_q == REQ_ID_W'(i))) begin
                grant_oh_s[i] = 1'b1;
                m_read        = req_read[i];
                m_write       = req_write[i] & ~req_read[i];
                m_address     = req_address[i*ADDR_W +: ADDR_W];
                m_writedata   = req_writedata[i*32 +: 32];
            end else begin
                grant_oh_s[i] = 1'b0;
            end
        end
        accept_s        = (state_q == ARB_ISSUE) & ~m_waitrequest;
        push_s          = accept_s & m_read;
        req_waitrequest = ~(grant_oh_s & {NUM_REQ{accept_s}});
    end

    // Route returned read data to the requester at the head of the owner FIFO.
    always_comb begin
        pop_s             = m_readdatavalid & ~fifo_empty_s;
        req_readdata      = m_readdata;
        req_readdatavalid = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pop_s && (fifo_head_s == REQ_ID_W'(i))) begin
                req_readdatavalid[i] = 1'b1;
            end else begin
                req_readdatavalid[i] = 1'b0;
            end
        end
    end

    // Arbitration FSM: register a grant in IDLE, hold ISSUE until the adapter accepts.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= ARB_IDLE;
            grant_q      <= '0;
            last_grant_q <= REQ_ID_W'(NUM_REQ - 1);
        end else begin
            case (state_q)
                ARB_IDLE: begin
                    if (pick_valid_s) begin
                        grant_q <= pick_id_s;
                        state_q <= ARB_ISSUE;
                    end
                end
                ARB_ISSUE: begin
                    if (accept_s) begin
                        last_grant_q <= grant_q;
                        state_q      <= ARB_IDLE;
                    end
                end
                default: state_q <= ARB_IDLE;
            endcase
        end
    end

    // Sticky flag for read data that arrives with no recorded owner.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            err_orphan_q <= 1'b0;
        end else if (m_readdatavalid && fifo_empty_s) begin
            err_orphan_q <= 1'b1;
        end
    end

    assign err_orphan = err_orphan_q;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Self-checking bench for sram_port_arbiter: directed scenarios plus a randomized run
// against a queue-based model of requesters, adapter and read-return ownership.
module tb_sram_port_arbiter;

    localparam int NR = 3;
    localparam int AW = 26;

    logic             clock = 1'b0;
    logic             reset;
    logic [NR-1:0]    req_read, req_write, req_waitrequest, req_readdatavalid;
    logic [NR*AW-1:0] req_address;
    logic [NR*32-1:0] req_writedata;
    logic [31:0]      req_readdata, m_writedata, m_readdata;
    logic             m_read, m_write, m_waitrequest, m_readdatavalid, err_orphan;
    logic [AW-1:0]    m_address;

    sram_port_arbiter #(.NUM_REQ(NR), .MAX_OUTSTANDING(4), .ADDR_W(AW)) dut (
        .clock(clock), .reset(reset),
        .req_read(req_read), .req_write(req_write), .req_address(req_address),
        .req_writedata(req_writedata), .req_waitrequest(req_waitrequest),
        .req_readdata(req_readdata), .req_readdatavalid(req_readdatavalid),
        .m_read(m_read), .m_write(m_write), .m_address(m_address),
        .m_writedata(m_writedata), .m_waitrequest(m_waitrequest),
        .m_readdata(m_readdata), .m_readdatavalid(m_readdatavalid),
        .err_orphan(err_orphan)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        int who; bit rd; bit wr; logic [AW-1:0] maddr; logic [31:0] mwd;
        bit xrd; logic [AW-1:0] xaddr; logic [31:0] xwd; logic [NR-1:0] wrq; int cyc;
    } acc_t;
    typedef struct { logic [NR-1:0] vec; logic [31:0] data; } ret_t;
    typedef struct { int owner; int due; logic [31:0] data; } pend_t;

    acc_t  acc_q[$];
    ret_t  ret_q[$];
    ret_t  exp_ret_q[$];
    pend_t pend_q[$];
    int    acc_seen, last_due, multi_acc;

    // requester and adapter model state
    bit            act[NR], isrd[NR], renew[NR];
    logic [AW-1:0] raddr[NR];
    logic [31:0]   rwd[NR];
    bit            wait_rand, auto_ret, man_ret, rand_start;
    logic [31:0]   man_data;

    // Expected winner from the arbitration rules; -1 when nobody is eligible.
    function automatic int model_pick(input int last, input bit [NR-1:0] mask);
`ifdef SRAM_ARB_PRIO0_EN
        if (mask[0]) return 0;
        for (int k = 1; k <= NR; k++) begin
            int c = (last + k) % NR;
            if (c != 0 && mask[c]) return c;
        end
`else
        for (int k = 1; k <= NR; k++) begin
            int c = (last + k) % NR;
            if (mask[c]) return c;
        end
`endif
        return -1;
    endfunction

    // Record accepted transactions and read returns, sampled on the falling edge.
    always @(negedge clock) begin
        int   n;
        acc_t a;
        ret_t r;
        n = 0;
        if (reset === 1'b1) begin
            for (int i = 0; i < NR; i++) begin
                if (req_waitrequest[i] === 1'b0) begin
                    a.who = i; a.rd = m_read; a.wr = m_write; a.maddr = m_address;
                    a.mwd = m_writedata; a.xrd = isrd[i]; a.xaddr = raddr[i];
                    a.xwd = rwd[i]; a.wrq = req_waitrequest; a.cyc = cyc;
                    acc_q.push_back(a);
                    n++;
                end
            end
            if (n > 1) multi_acc++;
            if (req_readdatavalid !== '0) begin
                r.vec = req_readdatavalid; r.data = req_readdata;
                ret_q.push_back(r);
            end
        end
    end

    // One clock of stimulus: retire accepted requests, then drive requesters and adapter.
    task automatic drive_cycle();
        @(posedge clock); #1;
        while (acc_seen < acc_q.size()) begin
            int    w;
            pend_t p;
            w = acc_q[acc_seen].who;
            if (acc_q[acc_seen].rd && auto_ret) begin
                p.owner = w;
                p.due   = cyc + int'($urandom_range(1, 6));
                if (p.due <= last_due) p.due = last_due + 1;
                last_due = p.due;
                p.data   = $urandom;
                pend_q.push_back(p);
            end
            if (renew[w]) begin
                raddr[w] = AW'($urandom);
                rwd[w]   = $urandom;
            end else begin
                act[w] = 1'b0;
            end
            acc_seen++;
        end
        for (int i = 0; i < NR; i++) begin
            if (rand_start && !act[i] && $urandom_range(0, 3) == 0) begin
                act[i]   = 1'b1;
                isrd[i]  = 1'($urandom_range(0, 1));
                raddr[i] = AW'($urandom);
                rwd[i]   = $urandom;
            end
            req_read[i]  = act[i] & isrd[i];
            req_write[i] = act[i] & ~isrd[i];
            req_address[i*AW +: AW]   = raddr[i];
            req_writedata[i*32 +: 32] = rwd[i];
        end
        m_waitrequest = wait_rand ? ($urandom_range(0, 2) == 0) : 1'b0;
        if (man_ret) begin
            m_readdatavalid = 1'b1;
            m_readdata      = man_data;
            man_ret         = 1'b0;
        end else if (auto_ret && pend_q.size() > 0 && pend_q[0].due <= cyc) begin
            ret_t e;
            e.vec  = NR'(1) << pend_q[0].owner;
            e.data = pend_q[0].data;
            exp_ret_q.push_back(e);
            m_readdatavalid = 1'b1;
            m_readdata      = pend_q[0].data;
            void'(pend_q.pop_front());
        end else begin
            m_readdatavalid = 1'b0;
            m_readdata      = $urandom;
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        req_read = '0; req_write = '0; req_address = '0; req_writedata = '0;
        m_waitrequest = 1'b0; m_readdata = '0; m_readdatavalid = 1'b0;
        for (int i = 0; i < NR; i++) begin
            act[i] = 1'b0; isrd[i] = 1'b0; renew[i] = 1'b0; raddr[i] = '0; rwd[i] = '0;
        end
        wait_rand = 1'b0; auto_ret = 1'b0; man_ret = 1'b0; rand_start = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        acc_q.delete(); ret_q.delete(); exp_ret_q.delete(); pend_q.delete();
        acc_seen = 0; last_due = 0; multi_acc = 0;
        reset = 1'b1;
    endtask

    task automatic run_until_acc(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < budget && acc_q.size() < n; c++) drive_cycle();
        ok = (acc_q.size() >= n);
    endtask

    task automatic drain(input int budget, output bit ok);
        bit busy;
        ok = 1'b0;
        for (int c = 0; c < budget && !ok; c++) begin
            busy = (pend_q.size() > 0);
            for (int i = 0; i < NR; i++) busy = busy | act[i];
            if (!busy) ok = 1'b1;
            else drive_cycle();
        end
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clock);
        total++; if (req_waitrequest !== 3'b111) begin bad++; $display("FAIL reset_wait got=%b exp=111", req_waitrequest); end
        total++; if (m_read !== 1'b0) begin bad++; $display("FAIL reset_m_read got=%b exp=0", m_read); end
        total++; if (m_write !== 1'b0) begin bad++; $display("FAIL reset_m_write got=%b exp=0", m_write); end
        total++; if (req_readdatavalid !== 3'b000) begin bad++; $display("FAIL reset_rdv got=%b exp=000", req_readdatavalid); end
        total++; if (err_orphan !== 1'b0) begin bad++; $display("FAIL reset_orphan got=%b exp=0", err_orphan); end
    endtask

    task automatic test_single_read();
        bit ok;
        do_reset();
        act[1] = 1'b1; isrd[1] = 1'b1; raddr[1] = 26'h100;
        run_until_acc(1, 20, ok);
        total++; if (!ok) begin bad++; $display("FAIL single_accept got=none exp=1 accept"); end
        if (ok) begin
            total++; if (acc_q[0].who !== 1 || acc_q[0].rd !== 1'b1) begin bad++; $display("FAIL single_who got=%0d/%b exp=1/1", acc_q[0].who, acc_q[0].rd); end
            total++; if (acc_q[0].maddr !== 26'h100) begin bad++; $display("FAIL single_addr got=%h exp=100", acc_q[0].maddr); end
            total++; if (acc_q[0].wrq !== 3'b101) begin bad++; $display("FAIL single_wait got=%b exp=101", acc_q[0].wrq); end
        end
        man_ret = 1'b1; man_data = 32'hDEADBEEF;
        drive_cycle(); @(negedge clock);
        total++; if (req_readdatavalid !== 3'b010) begin bad++; $display("FAIL single_rdv got=%b exp=010", req_readdatavalid); end
        total++; if (req_readdata !== 32'hDEADBEEF) begin bad++; $display("FAIL single_data got=%h exp=deadbeef", req_readdata); end
        drive_cycle(); @(negedge clock);
        total++; if (req_readdatavalid !== 3'b000) begin bad++; $display("FAIL single_rdv_pulse got=%b exp=000", req_readdatavalid); end
        total++; if (err_orphan !== 1'b0) begin bad++; $display("FAIL single_orphan got=%b exp=0", err_orphan); end
    endtask

    task automatic test_rr_writes();
        bit ok;
        int last, e;
        do_reset();
        for (int i = 0; i < NR; i++) begin
            act[i] = 1'b1; renew[i] = 1'b1; raddr[i] = AW'($urandom); rwd[i] = $urandom;
        end
        run_until_acc(9, 60, ok);
        total++; if (!ok) begin bad++; $display("FAIL rr_accepts got=%0d exp=9", acc_q.size()); end
        last = NR - 1;
        for (int k = 0; k < 9 && k < acc_q.size(); k++) begin
            e = model_pick(last, 3'b111);
            total++; if (acc_q[k].who !== e) begin bad++; $display("FAIL rr_grant[%0d] got=%0d exp=%0d", k, acc_q[k].who, e); end
            total++; if (acc_q[k].wr !== 1'b1 || acc_q[k].mwd !== acc_q[k].xwd || acc_q[k].maddr !== acc_q[k].xaddr)
                begin bad++; $display("FAIL rr_payload[%0d] got=%h@%h exp=%h@%h", k, acc_q[k].mwd, acc_q[k].maddr, acc_q[k].xwd, acc_q[k].xaddr); end
            if (k > 0) begin
                total++; if (acc_q[k].cyc - acc_q[k-1].cyc !== 2) begin bad++; $display("FAIL rr_spacing[%0d] got=%0d exp=2", k, acc_q[k].cyc - acc_q[k-1].cyc); end
            end
            last = e;
        end
        for (int i = 0; i < NR; i++) renew[i] = 1'b0;
        drain(40, ok);
        total++; if (!ok) begin bad++; $display("FAIL rr_drain got=busy exp=idle"); end
    endtask

    task automatic test_fifo_full();
        bit ok;
        int rc;
        do_reset();
        act[2] = 1'b1; isrd[2] = 1'b1; renew[2] = 1'b1; raddr[2] = AW'($urandom);
        repeat (24) drive_cycle();
        @(negedge clock);
        total++; if (acc_q.size() !== 4) begin bad++; $display("FAIL full_issued got=%0d exp=4", acc_q.size()); end
        total++; if (m_read !== 1'b0 || req_waitrequest !== 3'b111) begin bad++; $display("FAIL full_stall got=%b/%b exp=0/111", m_read, req_waitrequest); end
        man_ret = 1'b1; man_data = $urandom;
        drive_cycle(); rc = cyc; @(negedge clock);
        total++; if (req_readdatavalid !== 3'b100 || req_readdata !== man_data) begin bad++; $display("FAIL full_ret got=%b/%h exp=100/%h", req_readdatavalid, req_readdata, man_data); end
        repeat (10) drive_cycle();
        total++; if (acc_q.size() !== 5) begin bad++; $display("FAIL full_fifth got=%0d exp=5", acc_q.size()); end
        if (acc_q.size() >= 5) begin
            total++; if (acc_q[4].cyc <= rc) begin bad++; $display("FAIL full_order got=%0d exp>%0d", acc_q[4].cyc, rc); end
        end
        act[2] = 1'b0;
        drive_cycle();
    endtask

    task automatic test_interleave();
        bit ok;
        logic [31:0] da, db;
        do_reset();
        act[0] = 1'b1; isrd[0] = 1'b1; raddr[0] = 26'h10;
        act[1] = 1'b1; isrd[1] = 1'b1; raddr[1] = 26'h20;
        run_until_acc(2, 20, ok);
        total++; if (!ok) begin bad++; $display("FAIL il_accepts got=%0d exp=2", acc_q.size()); end
        if (ok) begin
            total++; if (acc_q[0].who !== 0 || acc_q[0].maddr !== 26'h10) begin bad++; $display("FAIL il_first got=%0d@%h exp=0@10", acc_q[0].who, acc_q[0].maddr); end
            total++; if (acc_q[1].who !== 1 || acc_q[1].maddr !== 26'h20) begin bad++; $display("FAIL il_second got=%0d@%h exp=1@20", acc_q[1].who, acc_q[1].maddr); end
        end
        da = $urandom; db = $urandom;
        man_ret = 1'b1; man_data = da; drive_cycle(); @(negedge clock);
        total++; if (req_readdatavalid !== 3'b001 || req_readdata !== da) begin bad++; $display("FAIL il_ret0 got=%b/%h exp=001/%h", req_readdatavalid, req_readdata, da); end
        man_ret = 1'b1; man_data = db; drive_cycle(); @(negedge clock);
        total++; if (req_readdatavalid !== 3'b010 || req_readdata !== db) begin bad++; $display("FAIL il_ret1 got=%b/%h exp=010/%h", req_readdatavalid, req_readdata, db); end
    endtask

    task automatic test_orphan();
        bit ok;
        do_reset();
        man_ret = 1'b1; man_data = $urandom;
        drive_cycle(); @(negedge clock);
        total++; if (req_readdatavalid !== 3'b000) begin bad++; $display("FAIL orphan_rdv got=%b exp=000", req_readdatavalid); end
        drive_cycle(); @(negedge clock);
        total++; if (err_orphan !== 1'b1) begin bad++; $display("FAIL orphan_set got=%b exp=1", err_orphan); end
        repeat (5) drive_cycle();
        @(negedge clock);
        total++; if (err_orphan !== 1'b1) begin bad++; $display("FAIL orphan_sticky got=%b exp=1", err_orphan); end
        // a read in flight across reset comes back as an orphan
        do_reset();
        @(negedge clock);
        total++; if (err_orphan !== 1'b0) begin bad++; $display("FAIL orphan_clear got=%b exp=0", err_orphan); end
        act[0] = 1'b1; isrd[0] = 1'b1; raddr[0] = AW'($urandom);
        run_until_acc(1, 20, ok);
        do_reset();
        man_ret = 1'b1; man_data = $urandom;
        drive_cycle(); @(negedge clock);
        total++; if (req_readdatavalid !== 3'b000) begin bad++; $display("FAIL midrst_rdv got=%b exp=000", req_readdatavalid); end
        drive_cycle(); @(negedge clock);
        total++; if (err_orphan !== 1'b1) begin bad++; $display("FAIL midrst_orphan got=%b exp=1", err_orphan); end
    endtask

    task automatic test_prio();
        bit ok;
        int last, e;
        do_reset();
        act[0] = 1'b1; renew[0] = 1'b1; rwd[0] = $urandom;
        act[2] = 1'b1; renew[2] = 1'b1; rwd[2] = $urandom;
        run_until_acc(6, 40, ok);
        total++; if (!ok) begin bad++; $display("FAIL prio_accepts got=%0d exp=6", acc_q.size()); end
        last = NR - 1;
        for (int k = 0; k < 6 && k < acc_q.size(); k++) begin
            e = model_pick(last, 3'b101);
            total++; if (acc_q[k].who !== e) begin bad++; $display("FAIL prio_grant[%0d] got=%0d exp=%0d", k, acc_q[k].who, e); end
            last = e;
        end
        renew[0] = 1'b0; renew[2] = 1'b0;
        drain(40, ok);
        total++; if (!ok) begin bad++; $display("FAIL prio_drain got=busy exp=idle"); end
    endtask

    task automatic test_random();
        bit ok;
        int nrd;
        do_reset();
        wait_rand = 1'b1; auto_ret = 1'b1; rand_start = 1'b1;
        repeat (600) drive_cycle();
        rand_start = 1'b0;
        drain(300, ok);
        repeat (3) drive_cycle();
        total++; if (!ok) begin bad++; $display("FAIL rnd_drain got=busy exp=idle"); end
        nrd = 0;
        foreach (acc_q[k]) begin
            if (acc_q[k].xrd) nrd++;
            total++;
            if (acc_q[k].rd !== acc_q[k].xrd || acc_q[k].wr !== !acc_q[k].xrd || acc_q[k].maddr !== acc_q[k].xaddr ||
                (!acc_q[k].xrd && acc_q[k].mwd !== acc_q[k].xwd)) begin
                bad++;
                $display("FAIL rnd_issue[%0d] got=r%b w%b %h %h exp=r%b %h %h", k, acc_q[k].rd, acc_q[k].wr,
                         acc_q[k].maddr, acc_q[k].mwd, acc_q[k].xrd, acc_q[k].xaddr, acc_q[k].xwd);
            end
        end
        total++; if (ret_q.size() !== exp_ret_q.size() || ret_q.size() !== nrd) begin bad++; $display("FAIL rnd_ret_count got=%0d exp=%0d/%0d", ret_q.size(), exp_ret_q.size(), nrd); end
        for (int k = 0; k < ret_q.size() && k < exp_ret_q.size(); k++) begin
            total++; if (ret_q[k].vec !== exp_ret_q[k].vec || ret_q[k].data !== exp_ret_q[k].data)
                begin bad++; $display("FAIL rnd_ret[%0d] got=%b/%h exp=%b/%h", k, ret_q[k].vec, ret_q[k].data, exp_ret_q[k].vec, exp_ret_q[k].data); end
        end
        total++; if (multi_acc !== 0) begin bad++; $display("FAIL rnd_multi_accept got=%0d exp=0", multi_acc); end
        total++; if (err_orphan !== 1'b0) begin bad++; $display("FAIL rnd_orphan got=%b exp=0", err_orphan); end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_rr_writes();
        test_fifo_full();
        test_interleave();
        test_orphan();
        test_prio();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
